// File: rtl/sram_port_arbiter.sv
// Two-port arbiter and strobe sequencer for a 16-bit async SRAM (A: read-only, B: read/write).
// Define SRAM_ARB_FAIR_EN to bound how long B can be starved by back-to-back A grants.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W       = 20,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned RD_WAIT      = 2,
  parameter int unsigned WR_WAIT      = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic [1:0]        b_be,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_ack,
  inout  wire  [DATA_W-1:0] sram_DQ,
  output logic [ADDR_W-1:0] sram_ADDR,
  output logic              sram_LB_N,
  output logic              sram_UB_N,
  output logic              sram_CE_N,
  output logic              sram_OE_N,
  output logic              sram_WE_N,
  output logic              busy
);

  localparam int unsigned MaxWait = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int unsigned CntW    = $clog2(MaxWait + 1);

  if (RD_WAIT == 0 || WR_WAIT == 0 || STARVE_LIMIT == 0) begin : g_bad_param
    $error("RD_WAIT, WR_WAIT and STARVE_LIMIT must all be at least 1");
  end

  typedef enum logic [2:0] {StIdle, StRead, StWrSetup, StWrPulse, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          lane_n_q, lane_n_d;  // {UB_N, LB_N} for the current access
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
  logic                own_b_q, own_b_d;
  logic                wr_q, wr_d;
  logic                pick_b;
  logic                dq_oe;

`ifdef SRAM_ARB_FAIR_EN
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  logic [StarveW-1:0] starve_q, starve_d;

  assign pick_b = b_req & (~a_req | (starve_q == StarveW'(STARVE_LIMIT)));

  // Count A grants made while B is waiting; any B grant forgives the debt.
  always_comb begin
    starve_d = starve_q;
    if (state_q == StIdle && (a_req || b_req)) begin
      if (pick_b) begin
        starve_d = '0;
      end else if (b_req) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign pick_b = b_req & ~a_req;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    lane_n_d  = lane_n_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    own_b_d   = own_b_q;
    wr_d      = wr_q;
    unique case (state_q)
      StIdle: begin
        if (a_req || b_req) begin
          own_b_d  = pick_b;
          wr_d     = pick_b & b_we;
          addr_d   = pick_b ? b_addr : a_addr;
          lane_n_d = (pick_b && b_we) ? ~b_be : 2'b00;
          if (pick_b && b_we) begin
            wdata_d = b_wdata;
          end
          cnt_d   = '0;
          state_d = (pick_b && b_we) ? StWrSetup : StRead;
        end
      end
      StRead: begin
        if (cnt_q == CntW'(RD_WAIT - 1)) begin
          state_d = StDone;
          if (own_b_q) begin
            b_rdata_d = sram_DQ;
          end else begin
            a_rdata_d = sram_DQ;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWrSetup: begin
        cnt_d   = '0;
        state_d = StWrPulse;
      end
      StWrPulse: begin
        if (cnt_q == CntW'(WR_WAIT - 1)) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      lane_n_q  <= 2'b11;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      own_b_q   <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      lane_n_q  <= lane_n_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      own_b_q   <= own_b_d;
      wr_q      <= wr_d;
    end
  end

  // Strobes decode straight from state so an async reset releases the bus at once.
  always_comb begin
    sram_CE_N = 1'b1;
    sram_OE_N = 1'b1;
    sram_WE_N = 1'b1;
    sram_LB_N = 1'b1;
    sram_UB_N = 1'b1;
    dq_oe     = 1'b0;
    unique case (state_q)
      StRead: begin
        sram_CE_N              = 1'b0;
        sram_OE_N              = 1'b0;
        {sram_UB_N, sram_LB_N} = lane_n_q;
      end
      StWrSetup: begin
        sram_CE_N              = 1'b0;
        {sram_UB_N, sram_LB_N} = lane_n_q;
        dq_oe                  = 1'b1;
      end
      StWrPulse: begin
        sram_CE_N              = 1'b0;
        sram_WE_N              = 1'b0;
        {sram_UB_N, sram_LB_N} = lane_n_q;
        dq_oe                  = 1'b1;
      end
      StDone:  dq_oe = wr_q;  // hold write data one cycle past WE_N rising
      default: ;
    endcase
  end

  assign sram_DQ   = dq_oe ? wdata_q : {DATA_W{1'bz}};
  assign sram_ADDR = addr_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign a_ack     = (state_q == StDone) & ~own_b_q;
  assign b_ack     = (state_q == StDone) & own_b_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomised self-checking bench for sram_port_arbiter against a word-level SRAM reference.
// Starvation expectations follow SRAM_ARB_FAIR_EN when it is defined for the build.
module tb_sram_port_arbiter;

  localparam int unsigned ADDR_W       = 20;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned RD_WAIT      = 2;
  localparam int unsigned WR_WAIT      = 2;
  localparam int unsigned STARVE_LIMIT = 4;

  logic              clk_clk = 1'b0;
  logic              reset_reset_n;
  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_rdata;
  logic              a_ack;
  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic [1:0]        b_be;
  logic [DATA_W-1:0] b_rdata;
  logic              b_ack;
  wire  [DATA_W-1:0] sram_DQ;
  logic [ADDR_W-1:0] sram_ADDR;
  logic              sram_LB_N, sram_UB_N, sram_CE_N, sram_OE_N, sram_WE_N;
  logic              busy;
  logic              probe;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] ref_mem [4096];
  logic [15:0] pin_mem [4096];

  always #5 clk_clk = ~clk_clk;

  sram_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .RD_WAIT     (RD_WAIT),
    .WR_WAIT     (WR_WAIT),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .a_req        (a_req),
    .a_addr       (a_addr),
    .a_rdata      (a_rdata),
    .a_ack        (a_ack),
    .b_req        (b_req),
    .b_we         (b_we),
    .b_addr       (b_addr),
    .b_wdata      (b_wdata),
    .b_be         (b_be),
    .b_rdata      (b_rdata),
    .b_ack        (b_ack),
    .sram_DQ      (sram_DQ),
    .sram_ADDR    (sram_ADDR),
    .sram_LB_N    (sram_LB_N),
    .sram_UB_N    (sram_UB_N),
    .sram_CE_N    (sram_CE_N),
    .sram_OE_N    (sram_OE_N),
    .sram_WE_N    (sram_WE_N),
    .busy         (busy)
  );

  function automatic logic [15:0] init_word(input logic [11:0] a);
    return {a, 4'h0} ^ 16'hA5C3;
  endfunction

  // Pin-level SRAM: drives DQ on OE_N, stores enabled lanes while WE_N is low.
  assign sram_DQ = (!sram_CE_N && !sram_OE_N && sram_WE_N) ? pin_mem[sram_ADDR[11:0]]
                                                           : 16'hzzzz;
  // Bench-side keeper used to prove nobody else is driving the bus.
  assign sram_DQ = probe ? 16'hC3C3 : 16'hzzzz;

  initial begin
    for (int i = 0; i < 4096; i++) pin_mem[i] = init_word(12'(i));
    forever begin
      @(negedge clk_clk);
      if (!sram_CE_N && !sram_WE_N) begin
        if (!sram_LB_N) pin_mem[sram_ADDR[11:0]][7:0]  = sram_DQ[7:0];
        if (!sram_UB_N) pin_mem[sram_ADDR[11:0]][15:8] = sram_DQ[15:8];
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_dq_free(input string tag);
    probe = 1'b1;
    #1;
    check_eq(tag, 32'(sram_DQ), 32'h0000C3C3);
    probe = 1'b0;
    #1;
  endtask

  task automatic check_reset_state();
    check_eq("rst_strobes", 32'({sram_CE_N, sram_OE_N, sram_WE_N, sram_LB_N, sram_UB_N}),
             32'h1F);
    check_eq("rst_acks", 32'({a_ack, b_ack}), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_addr", 32'(sram_ADDR), 32'h0);
    check_eq("rst_rdata", 32'({a_rdata, b_rdata}), 32'h0);
    check_dq_free("rst_dq_free");
  endtask

  // One complete access on port A (read) or B; checks latency, pins and data.
  task automatic xfer(input bit use_b, input bit we, input logic [11:0] addr,
                      input logic [15:0] wd, input logic [1:0] be, output logic [15:0] rd);
    int          cyc    = 0;
    int          we_cnt = 0;
    bit          got    = 0;
    bit          bad_w  = 0;
    bit          bad_r  = 0;
    bit          bad_a  = 0;
    bit          stray  = 0;
    logic [19:0] full   = {8'h00, addr};
    rd = '0;
    check_eq("start_idle", 32'(busy), 32'h0);
    if (use_b) begin
      b_req = 1'b1; b_we = we; b_addr = full; b_wdata = wd; b_be = be;
    end else begin
      a_req = 1'b1; a_addr = full;
    end
    while (!got && cyc < 40) begin
      @(negedge clk_clk);
      cyc++;
      if (!sram_WE_N) begin
        we_cnt++;
        if (sram_DQ !== wd || {sram_UB_N, sram_LB_N} !== ~be || sram_OE_N !== 1'b1) bad_w = 1;
      end
      if (!sram_OE_N && {sram_UB_N, sram_LB_N} !== 2'b00) bad_r = 1;
      if (!sram_CE_N && sram_ADDR !== full) bad_a = 1;
      if (use_b ? a_ack : b_ack) stray = 1;
      if (use_b ? b_ack : a_ack) begin
        got = 1;
        rd  = use_b ? b_rdata : a_rdata;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    check_eq("ack_latency", got ? 32'(cyc) : 32'hFFFF, we ? 32'(WR_WAIT + 2) : 32'(RD_WAIT + 1));
    check_eq("addr_on_pins", 32'(bad_a), 32'h0);
    check_eq("stray_ack", 32'(stray), 32'h0);
    if (we) begin
      check_eq("we_low_cycles", 32'(we_cnt), 32'(WR_WAIT));
      check_eq("write_pins", 32'(bad_w), 32'h0);
      check_eq("wr_done_hold", 32'(sram_DQ), 32'(wd));
      if (be[0]) ref_mem[addr][7:0]  = wd[7:0];
      if (be[1]) ref_mem[addr][15:8] = wd[15:8];
    end else begin
      check_eq("read_data", 32'(rd), 32'(ref_mem[addr]));
      check_eq("read_lanes", 32'(bad_r), 32'h0);
    end
    @(negedge clk_clk);
    if (we) check_dq_free("dq_released");
  endtask

  logic [15:0] rd;
  logic [15:0] rd_a;
  logic [15:0] rd_b;
  int          ta, tb, cyc, na, nb, a_before;
  bit          seen, overlap;

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(12'(i));
    probe = 1'b0;
    reset_reset_n = 1'b0;
    a_req = 1'b0; a_addr = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = 2'b00;
    repeat (2) @(negedge clk_clk);
    check_reset_state();
    reset_reset_n = 1'b1;
    @(negedge clk_clk);

    // Full write then readback, byte write, and an all-lanes-disabled write.
    xfer(1, 1, 12'h03A, 16'hBEEF, 2'b11, rd);
    xfer(1, 0, 12'h03A, 16'h0000, 2'b00, rd);
    check_eq("readback_beef", 32'(rd), 32'h0000BEEF);
    xfer(1, 1, 12'h03A, 16'h12AB, 2'b01, rd);
    xfer(1, 0, 12'h03A, 16'h0000, 2'b00, rd);
    check_eq("readback_beab", 32'(rd), 32'h0000BEAB);
    xfer(1, 1, 12'h03A, 16'h0000, 2'b00, rd);
    xfer(0, 0, 12'h03A, 16'h0000, 2'b00, rd);
    check_eq("be00_no_change", 32'(rd), 32'h0000BEAB);

    // Simultaneous requests: A wins, B follows after one idle cycle.
    a_addr = 20'h00200; b_we = 1'b0; b_addr = 20'h00100;
    a_req = 1'b1; b_req = 1'b1;
    ta = 0; tb = 0; cyc = 0; overlap = 0;
    while ((ta == 0 || tb == 0) && cyc < 60) begin
      @(negedge clk_clk);
      cyc++;
      if (a_ack && b_ack) overlap = 1;
      if (!sram_OE_N && !sram_WE_N) overlap = 1;
      if (a_ack) begin ta = cyc; rd_a = a_rdata; a_req = 1'b0; end
      if (b_ack) begin tb = cyc; rd_b = b_rdata; b_req = 1'b0; end
    end
    a_req = 1'b0; b_req = 1'b0;
    check_eq("both_a_first", 32'(ta), 32'(RD_WAIT + 1));
    check_eq("both_b_after", 32'(tb), 32'(2 * (RD_WAIT + 1) + 1));
    check_eq("both_a_data", 32'(rd_a), 32'(ref_mem[12'h200]));
    check_eq("both_b_data", 32'(rd_b), 32'(ref_mem[12'h100]));
    check_eq("both_overlap", 32'(overlap), 32'h0);
    @(negedge clk_clk);

    // A held continuously while B waits.
    check_eq("starve_start_idle", 32'(busy), 32'h0);
    a_addr = 20'h00010; b_we = 1'b0; b_addr = 20'h00020;
    a_req = 1'b1; b_req = 1'b1;
    na = 0; nb = 0; a_before = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_clk);
      if (a_ack) na++;
      if (b_ack) begin
        if (nb == 0) a_before = na;
        nb++;
        b_req = 1'b0;
      end
    end
`ifdef SRAM_ARB_FAIR_EN
    check_eq("fair_a_before_b", 32'(a_before), 32'(STARVE_LIMIT));
    check_eq("fair_b_acks", 32'(nb), 32'h1);
`else
    check_eq("strict_b_starved", 32'(nb), 32'h0);
    check_eq("strict_a_acks", 32'(na), 32'((100 - (RD_WAIT + 1)) / (RD_WAIT + 2) + 1));
`endif
    a_req = 1'b0; b_req = 1'b0;
    repeat (10) @(negedge clk_clk);

    // Asynchronous reset while idle, after pins have been used.
    #2 reset_reset_n = 1'b0;
    #1 check_reset_state();
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);

    // Reset during the write pulse: bus released at once and no ack.
    b_req = 1'b1; b_we = 1'b1; b_addr = 20'h00055; b_wdata = 16'h1234; b_be = 2'b11;
    cyc = 0;
    while (sram_WE_N && cyc < 20) begin
      @(negedge clk_clk);
      cyc++;
    end
    check_eq("reached_wr_pulse", 32'(sram_WE_N), 32'h0);
    #2 reset_reset_n = 1'b0;
    #1;
    check_eq("rst_pulse_we_ce", 32'({sram_WE_N, sram_CE_N}), 32'h3);
    check_eq("rst_pulse_busy", 32'(busy), 32'h0);
    check_dq_free("rst_pulse_dq_free");
    b_req = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk_clk);
      if (b_ack) seen = 1;
    end
    check_eq("rst_pulse_no_ack", 32'(seen), 32'h0);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    xfer(1, 1, 12'h055, 16'h1234, 2'b11, rd);
    xfer(1, 0, 12'h055, 16'h0000, 2'b00, rd);
    check_eq("reissued_write", 32'(rd), 32'h00001234);

    // Random mix of A reads, B reads and B byte-masked writes.
    for (int i = 0; i < 60; i++) begin
      int unsigned kind;
      logic [11:0] ra;
      logic [15:0] rw;
      logic [1:0]  rb;
      kind = $urandom_range(0, 2);
      ra   = 12'($urandom_range(0, 4095));
      rw   = 16'($urandom);
      rb   = 2'($urandom_range(0, 3));
      if (kind == 0)      xfer(0, 0, ra, 16'h0000, 2'b00, rd);
      else if (kind == 1) xfer(1, 0, ra, 16'h0000, 2'b00, rd);
      else                xfer(1, 1, ra, rw, rb, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
